// File: rtl/alu_multicycle.sv
// Purpose: single-issue ALU; add/sub/logic/shift/slt in one cycle, unsigned mul by shift-add.
// Latency: non-mul result valid the cycle after accept; mul result valid WIDTH cycles after accept.
// Backpressure: result and flags held while out_valid && !out_ready; in_ready low during MUL.
//
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   in_valid/in_ready      request handshake; a, b, op captured on the accept edge
//   out_valid/out_ready    result handshake; out plus zero/neg/carry/ovf/illegal flags
module alu_multicycle #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             zero,
    output logic             neg,
    output logic             carry,
    output logic             ovf,
    output logic             illegal
);
    localparam int SHW = $clog2(WIDTH);
    localparam logic [SHW-1:0] CNT_LAST = SHW'(WIDTH - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b1000;
    localparam logic [3:0] OP_AND = 4'b0111;
    localparam logic [3:0] OP_OR  = 4'b0110;
    localparam logic [3:0] OP_XOR = 4'b0011;
    localparam logic [3:0] OP_SLL = 4'b0001;
    localparam logic [3:0] OP_SRL = 4'b0101;
    localparam logic [3:0] OP_SRA = 4'b1101;
    localparam logic [3:0] OP_SLT = 4'b0010;
    localparam logic [3:0] OP_MUL = 4'b1001;

    logic [1:0]         state_q, state_d;
    logic [WIDTH-1:0]   out_q, out_d;
    logic               zero_q, zero_d, neg_q, neg_d, carry_q, carry_d;
    logic               ovf_q, ovf_d, illegal_q, illegal_d;
    logic [2*WIDTH-1:0] acc_q, acc_d, mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [SHW-1:0]     cnt_q, cnt_d;

    logic               accept;
    logic [WIDTH:0]     sum_ext, diff_ext;
    logic [SHW-1:0]     shamt;
    logic [WIDTH-1:0]   alu_res;
    logic               alu_carry, alu_ovf, alu_ill, is_mul;
    logic [2*WIDTH-1:0] acc_step;

    assign in_ready  = (state_q == S_IDLE) || ((state_q == S_DONE) && out_ready);
    assign out_valid = (state_q == S_DONE);
    assign accept    = in_valid && in_ready;

    assign out     = out_q;
    assign zero    = zero_q;
    assign neg     = neg_q;
    assign carry   = carry_q;
    assign ovf     = ovf_q;
    assign illegal = illegal_q;

    assign sum_ext  = {1'b0, a} + {1'b0, b};
    assign diff_ext = {1'b0, a} - {1'b0, b};
    assign shamt    = b[SHW-1:0];

    // Single-cycle datapath, evaluated on the live inputs so the result can be
    // registered on the same edge that accepts the request.
    always_comb begin
        alu_res   = '0;
        alu_carry = 1'b0;
        alu_ovf   = 1'b0;
        alu_ill   = 1'b0;
        is_mul    = 1'b0;
        case (op)
            OP_ADD: begin
                alu_res   = sum_ext[WIDTH-1:0];
                alu_carry = sum_ext[WIDTH];
                alu_ovf   = (a[WIDTH-1] == b[WIDTH-1]) && (sum_ext[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res   = diff_ext[WIDTH-1:0];
                alu_carry = ~diff_ext[WIDTH];   // no borrow means a >= b unsigned
                alu_ovf   = (a[WIDTH-1] != b[WIDTH-1]) && (diff_ext[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND: alu_res = a & b;
            OP_OR:  alu_res = a | b;
            OP_XOR: alu_res = a ^ b;
            OP_SLL: alu_res = a << shamt;
            OP_SRL: alu_res = a >> shamt;
            OP_SRA: alu_res = WIDTH'($signed(a) >>> shamt);
            OP_SLT: alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_MUL: is_mul = 1'b1;
            default: alu_ill = 1'b1;
        endcase
    end

    // One multiplier bit per MUL cycle; the multiplicand shifts left in a
    // double-width register so the full product is available for ovf.
    assign acc_step = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

    always_comb begin
        state_d   = state_q;
        out_d     = out_q;
        zero_d    = zero_q;
        neg_d     = neg_q;
        carry_d   = carry_q;
        ovf_d     = ovf_q;
        illegal_d = illegal_q;
        acc_d     = acc_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        cnt_d     = cnt_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (accept) begin
                    if (is_mul) begin
                        // out/flags keep their old value until the product lands
                        state_d  = S_MUL;
                        acc_d    = '0;
                        mcand_d  = {{WIDTH{1'b0}}, a};
                        mplier_d = b;
                        cnt_d    = '0;
                    end else begin
                        state_d   = S_DONE;
                        out_d     = alu_res;
                        zero_d    = (alu_res == '0);
                        neg_d     = alu_res[WIDTH-1];
                        carry_d   = alu_carry;
                        ovf_d     = alu_ovf;
                        illegal_d = alu_ill;
                    end
                end else if (state_q == S_DONE && out_ready) begin
                    state_d = S_IDLE;
                end
            end
            S_MUL: begin
                acc_d    = acc_step;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + SHW'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d   = S_DONE;
                    cnt_d     = '0;
                    out_d     = acc_step[WIDTH-1:0];
                    zero_d    = (acc_step[WIDTH-1:0] == '0);
                    neg_d     = acc_step[WIDTH-1];
                    carry_d   = 1'b0;
                    ovf_d     = |acc_step[2*WIDTH-1:WIDTH];
                    illegal_d = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            out_q     <= '0;
            zero_q    <= 1'b0;
            neg_q     <= 1'b0;
            carry_q   <= 1'b0;
            ovf_q     <= 1'b0;
            illegal_q <= 1'b0;
            acc_q     <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            out_q     <= out_d;
            zero_q    <= zero_d;
            neg_q     <= neg_d;
            carry_q   <= carry_d;
            ovf_q     <= ovf_d;
            illegal_q <= illegal_d;
            acc_q     <= acc_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            cnt_q     <= cnt_d;
        end
    end
endmodule

// File: tb/tb_alu_multicycle.sv
module tb_alu_multicycle;
    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b1000;
    localparam logic [3:0] OP_AND = 4'b0111;
    localparam logic [3:0] OP_SLL = 4'b0001;
    localparam logic [3:0] OP_SRA = 4'b1101;
    localparam logic [3:0] OP_SLT = 4'b0010;
    localparam logic [3:0] OP_MUL = 4'b1001;

    logic        clk = 1'b0;
    logic        rst_n, in_valid, out_ready, sel;
    logic [63:0] a_i, b_i;
    logic [3:0]  op_i;

    logic        rdy64, vld64, z64, n64, c64, v64, i64;
    logic [63:0] out64;
    logic        rdy8, vld8, z8, n8, c8, v8, i8;
    logic [7:0]  out8;

    logic        o_in_ready, o_valid;
    logic [63:0] o_out;
    logic [4:0]  o_flags;   // {zero, neg, carry, ovf, illegal}

    always #5 clk = ~clk;

    alu_multicycle #(.WIDTH(64)) u_alu64 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid && !sel), .in_ready(rdy64),
        .a(a_i), .b(b_i), .op(op_i), .out_valid(vld64), .out_ready(out_ready),
        .out(out64), .zero(z64), .neg(n64), .carry(c64), .ovf(v64), .illegal(i64)
    );

    alu_multicycle #(.WIDTH(8)) u_alu8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid && sel), .in_ready(rdy8),
        .a(a_i[7:0]), .b(b_i[7:0]), .op(op_i), .out_valid(vld8), .out_ready(out_ready),
        .out(out8), .zero(z8), .neg(n8), .carry(c8), .ovf(v8), .illegal(i8)
    );

    assign o_in_ready = sel ? rdy8 : rdy64;
    assign o_valid    = sel ? vld8 : vld64;
    assign o_out      = sel ? {56'b0, out8} : out64;
    assign o_flags    = sel ? {z8, n8, c8, v8, i8} : {z64, n64, c64, v64, i64};

    typedef struct {
        logic [63:0] out;
        logic [4:0]  flags;
        int          lat;     // clock edges after the accept edge before out_valid
        string       tag;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Called away from the rising edge; returns just after the accept edge.
    task automatic apply(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                         input logic push_it, input logic [63:0] eo, input logic [4:0] ef,
                         input int el, input string tag);
        int guard = 0;
        in_valid = 1'b1;
        op_i = op;
        a_i = a;
        b_i = b;
        #1;
        while (!o_in_ready && guard < 200) begin
            @(negedge clk);
            #1;
            guard++;
        end
        if (guard >= 200) check({tag, " accept_timeout"}, {63'b0, o_in_ready}, 64'd1);
        if (push_it) sb.push_back('{eo, ef, el, tag});
        @(posedge clk);
    endtask

    // Waits for out_valid, then compares against the oldest scoreboard entry.
    // With poke set, a competing request is held on the inputs while waiting.
    task automatic collect(input logic poke);
        exp_t e;
        int   k = 0;
        logic rdy_seen = 1'b0;
        @(negedge clk);
        if (poke) begin
            op_i = OP_ADD;
            a_i = 64'd1;
            b_i = 64'd1;
        end else begin
            in_valid = 1'b0;
        end
        #1;
        while (!o_valid && k < 200) begin
            rdy_seen |= o_in_ready;
            @(posedge clk);
            k++;
            @(negedge clk);
            #1;
        end
        in_valid = 1'b0;
        vectors++;
        assert (sb.size() != 0) else begin
            miscompares++;
            $error("FAIL scoreboard_underflow: observed 0 entries expected 1");
        end
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check({e.tag, " out"}, o_out, e.out);
            check({e.tag, " flags"}, {59'b0, o_flags}, {59'b0, e.flags});
            check({e.tag, " latency"}, 64'(k), 64'(e.lat));
            if (e.lat > 0) check({e.tag, " in_ready_during_mul"}, {63'b0, rdy_seen}, 64'd0);
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        sel = 1'b0;
        a_i = '0;
        b_i = '0;
        op_i = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            #1;
            check("reset in_ready", {63'b0, o_in_ready}, 64'd1);
            check("reset out_valid", {63'b0, o_valid}, 64'd0);
            check("reset out", o_out, 64'd0);
            check("reset flags", {59'b0, o_flags}, 64'd0);
        end

        // ---- WIDTH=64, consumer always ready (back-to-back issue) ----
        sel = 1'b0;
        apply(OP_ADD, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b1, 64'd0, 5'b10100, 0, "add64_wrap");
        collect(1'b0);
        apply(OP_SUB, 64'h8000_0000_0000_0000, 64'd1, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 5'b00110, 0, "sub64_ovf");
        collect(1'b0);
        apply(OP_SUB, 64'd1, 64'd2, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 5'b01000, 0, "sub64_borrow");
        collect(1'b0);
        apply(OP_SLT, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b1, 64'd1, 5'b00000, 0, "slt64_signed");
        collect(1'b0);
        apply(OP_SLL, 64'd1, 64'h43, 1'b1, 64'd8, 5'b00000, 0, "sll64_shamt_mask");
        collect(1'b0);
        apply(OP_SRA, 64'h8000_0000_0000_0000, 64'd63, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 5'b01000, 0, "sra64");
        collect(1'b0);
        apply(OP_MUL, 64'h1_0000_0001, 64'd3, 1'b1, 64'h3_0000_0003, 5'b00000, 64, "mul64");
        collect(1'b1);
        apply(OP_MUL, 64'h1_0000_0000, 64'h1_0000_0000, 1'b1, 64'd0, 5'b10010, 64, "mul64_ovf");
        collect(1'b0);
        apply(4'b1111, 64'd5, 64'd3, 1'b1, 64'd0, 5'b10001, 0, "illegal64_1111");
        collect(1'b0);
        apply(4'b1010, 64'd5, 64'd3, 1'b1, 64'd0, 5'b10001, 0, "illegal64_1010");
        collect(1'b0);

        // ---- WIDTH=8: mul with backpressure, then back-to-back AND ----
        @(negedge clk);
        sel = 1'b1;
        out_ready = 1'b0;
        apply(OP_MUL, 64'h10, 64'h11, 1'b1, 64'h10, 5'b00010, 8, "mul8");
        collect(1'b1);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            @(negedge clk);
            #1;
            check("bp out_valid", {63'b0, o_valid}, 64'd1);
            check("bp out", o_out, 64'h10);
            check("bp flags", {59'b0, o_flags}, {59'b0, 5'b00010});
            check("bp in_ready", {63'b0, o_in_ready}, 64'd0);
        end
        out_ready = 1'b1;
        apply(OP_AND, 64'hAA, 64'h0F, 1'b1, 64'h0A, 5'b00000, 0, "and8_b2b");
        collect(1'b0);

        // ---- WIDTH=8: reset three cycles into a multiply ----
        apply(OP_MUL, 64'hFF, 64'hFF, 1'b0, 64'd0, 5'b00000, 8, "mul8_aborted");
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        check("mul8 hold out_valid", {63'b0, o_valid}, 64'd0);
        check("mul8 hold out", o_out, 64'h0A);
        rst_n = 1'b0;
        #1;
        check("midmul reset out_valid", {63'b0, o_valid}, 64'd0);
        check("midmul reset out", o_out, 64'd0);
        check("midmul reset flags", {59'b0, o_flags}, 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("post reset in_ready", {63'b0, o_in_ready}, 64'd1);
        apply(OP_SRA, 64'h80, 64'h09, 1'b1, 64'hC0, 5'b01000, 0, "sra8");
        collect(1'b0);

        @(negedge clk);
        #1;
        check("final idle out_valid", {63'b0, o_valid}, 64'd0);
        check("final scoreboard empty", 64'(sb.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
